seq_uart_tx: RTL
================

// Module: seq_uart_tx
// PURPOSE
//   UART transmitter: serialises one byte per request from the sequencer send path.
//   Consumes tx_data/tx_valid and returns tx_busy, which the sequencer uses to gate its send.
//   Drives the board serial line 8N1 (8E1 with parity), LSB first.
// PARAMETERS
//   CLK_HZ   100_000_000  input clock frequency in Hz
//   BAUD     115_200      line rate in bits/s
//   DATA_W   8            payload bits per frame
//   DIV      CLK_HZ/BAUD  (localparam) clocks per bit, integer-truncated; DIV<2 is an elaboration error
// PORTS
//   clk         in   1       single clock, all logic rising-edge
//   rst         in   1       synchronous, active-low reset (rst==0 resets on clk edge)
//   i_tx_data   in   DATA_W  byte to send; sampled only on the accept cycle
//   i_tx_valid  in   1       send request
//   o_tx_busy   out  1       frame in progress; requests ignored while high
//   o_tx        out  1       serial line, idle high
//   o_tx_done   out  1       one-cycle pulse on the last clock of the stop bit
// BEHAVIOUR
//   - Reset (rst==0 at edge): state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, counters=0, shift reg=0.
//   - Accept: i_tx_valid & ~o_tx_busy in IDLE. i_tx_data latched into shift reg that edge.
//     From the next cycle: o_tx_busy=1, o_tx=0 (start bit). All outputs registered.
//   - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//     Each of START/PARITY/STOP lasts exactly DIV clocks; DATA lasts DATA_W*DIV clocks.
//   - Baud counter: 0..DIV-1, cleared on accept and on each state change; bit advances at DIV-1.
//   - DATA: o_tx = shift_reg[0]; shift right at each bit boundary; bit counter 0..DATA_W-1.
//   - STOP: o_tx=1; o_tx_done=1 on its final clock; next cycle o_tx_busy=0, state=IDLE.
//   - Frame length: (DATA_W+2)*DIV clocks of busy (one more DIV with parity).
//   - Back-to-back: valid held high re-accepts on the first cycle busy is low. The new start bit
//     follows the previous stop bit with exactly one extra clock of idle high.
//   - i_tx_valid and i_tx_data changes while busy are ignored; the latched byte is sent unaltered.
//   - No queueing: a request during busy is dropped, not deferred.
//   - Reset mid-frame: the line returns high on the next edge with rst low; frame is abandoned; no o_tx_done.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: PARITY state inserted after DATA.
//     o_tx = ^latched byte (even parity); frame (DATA_W+3)*DIV clocks.
//   Undefined: no PARITY state; 8N1 frame of (DATA_W+2)*DIV clocks.
// TESTING  (bench params CLK_HZ=1000, BAUD=100 -> DIV=10)
//   - Reset: hold rst=0 for 3 clks -> o_tx=1, o_tx_busy=0, o_tx_done=0.
//   - Single 0xA5 pulse -> o_tx bits 0,1,0,1,0,0,1,0,1,1, 10 clks each.
//     busy high exactly 100 clks; done pulses on clk 100.
//   - Valid held high with 0x3C then 0x3C->0xFF mid-frame -> first frame carries 0x3C.
//     The second frame (0xFF) starts 1 clk after busy falls.
//   - Reset at clk 45 of frame -> o_tx=1 and busy=0 next edge, no done.
//     A fresh 0x01 send completes normally afterwards.
//   - UART_TX_PARITY_EN, send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1.
//     busy high exactly 110 clks.
//   - Valid pulse on the same cycle o_tx_done=1 -> ignored; line stays idle high.

Source files
------------

// File: rtl/seq_uart_tx.sv
// seq_uart_tx: UART transmitter, one DATA_W-bit frame per request, LSB first, 8N1 (8E1 with UART_TX_PARITY_EN).
// Latency: start bit appears the cycle after accept; frame is (DATA_W+2)*DIV clocks, +DIV with parity.
// Backpressure: o_tx_busy is high for the whole frame; requests seen while busy are dropped, never queued.
module seq_uart_tx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115_200,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_busy,
  output logic              o_tx,
  output logic              o_tx_done
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  // A bit period shorter than two clocks cannot be timed by the baud counter.
  generate
    if (DIV < 2) begin : g_div_check
      $error("seq_uart_tx: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_d, busy_d, done_d;
  logic              cnt_last;
`ifdef UART_TX_PARITY_EN
  // Even parity of the accepted byte, captured before the shift register consumes it.
  logic              parity_q, parity_d;
`endif

  assign cnt_last = (cnt_q == CNT_LAST);

  // Next-state and next-output logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_tx_valid && !o_tx_busy) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = i_tx_data;
`ifdef UART_TX_PARITY_EN
          parity_d = ^i_tx_data;
`endif
        end
      end
      START: begin
        if (cnt_last) begin
          state_d = DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (cnt_last) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase

    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  // State, counters, shift register and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      o_tx      <= 1'b1;
      o_tx_busy <= 1'b0;
      o_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      o_tx      <= tx_d;
      o_tx_busy <= busy_d;
      o_tx_done <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
